// File: rtl/pwm_sched_pkg.sv
// Shared definitions for the PWM frame scheduler: FSM state encoding and
// default frame geometry.
package pwm_sched_pkg;

  localparam int SLOTS_DEF      = 4;
  localparam int SLOT_TICKS_DEF = 4;
  localparam int PRESCALE_DEF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Divides clk down to a one-cycle tick enable every PRESCALE cycles while en
// is high; the count is held at zero while en is low.
module pwm_tick_prescaler
  import pwm_sched_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_cnt;

  // Idle holds the count at zero so every run starts a full tick period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/pwm_frame_sched.sv
// Frame-based PWM player: SLOTS duty slots of SLOT_TICKS ticks each, with a
// shadow duty table that is committed to the active table at frame boundaries.
module pwm_frame_sched
  import pwm_sched_pkg::*;
#(
  parameter int SLOTS      = SLOTS_DEF,
  parameter int SLOT_TICKS = SLOT_TICKS_DEF,
  parameter int DW         = 3,
  parameter int PRESCALE   = PRESCALE_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(SLOTS)-1:0] wr_slot,
  input  logic [DW-1:0]            wr_duty,
  input  logic                     commit,
  output logic                     pwm_out,
  output logic [$clog2(SLOTS)-1:0] slot_idx,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     commit_pending
);

  localparam int SW = $clog2(SLOTS);
  localparam int TW = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;

  sched_state_e  r_state;
  logic [1:0]    r_sync;
  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_slot;
  logic [DW-1:0] r_shadow [SLOTS];
  logic [DW-1:0] r_active [SLOTS];
  logic [DW-1:0] w_shadow_nxt [SLOTS];
  logic          r_pending;
  logic          r_pwm;
  logic          r_frame_done;
  logic          r_busy;
  logic          w_rst_n;
  logic          w_run_en;
  logic          w_tick;
  logic          w_tick_last;
  logic          w_bound;
  logic          w_wr_fire;
  logic          w_start_go;

  function automatic logic [DW-1:0] sat_duty(input logic [DW-1:0] d);
    if (d > DW'(SLOT_TICKS)) return DW'(SLOT_TICKS);
    else return d;
  endfunction

  // Reset asserts asynchronously but releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], 1'b1};
  end
  assign w_rst_n = r_sync[1];

  assign w_run_en    = (r_state != ST_IDLE);
  assign w_wr_fire   = wr_valid && !r_pending;
  assign w_start_go  = (r_state == ST_IDLE) && start && !stop;
  assign w_tick_last = (r_tick_cnt == TW'(SLOT_TICKS - 1));
  assign w_bound     = w_tick && w_tick_last && (r_slot == SW'(SLOTS - 1));

  pwm_tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .rst_n (w_rst_n),
    .en    (w_run_en),
    .tick  (w_tick)
  );

  // Shadow table as it will look after this cycle's accepted write.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (w_wr_fire) w_shadow_nxt[wr_slot] = sat_duty(wr_duty);
    else           w_shadow_nxt = r_shadow;
  end

  // A start together with a commit takes the fresh shadow before the first tick.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_pending <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nxt;
      if (w_start_go && (r_pending || commit)) begin
        r_active  <= w_shadow_nxt;
        r_pending <= 1'b0;
      end else if (r_pending && ((r_state == ST_IDLE) || w_bound)) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end else if (commit) begin
        r_pending <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

  // Playback FSM with slot/tick position and registered PWM outputs.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= ST_IDLE;
      r_tick_cnt   <= '0;
      r_slot       <= '0;
      r_pwm        <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= w_bound;
      r_pwm        <= w_run_en && (DW'(r_tick_cnt) < r_active[r_slot]);
      case (r_state)
        ST_IDLE: begin
          r_tick_cnt <= '0;
          r_slot     <= '0;
          if (w_start_go) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN, ST_DRAIN: begin
          if (w_tick && w_tick_last) begin
            r_tick_cnt <= '0;
            r_slot     <= (r_slot == SW'(SLOTS - 1)) ? '0 : r_slot + SW'(1);
          end else if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
          if (w_bound && (r_state == ST_DRAIN)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if ((r_state == ST_RUN) && stop) begin
            r_state <= ST_DRAIN;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_tick_cnt <= '0;
          r_slot     <= '0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready       = !r_pending;
  assign commit_pending = r_pending;
  assign pwm_out        = r_pwm;
  assign slot_idx       = r_slot;
  assign frame_done     = r_frame_done;
  assign busy           = r_busy;

endmodule

// File: tb/tb_pwm_frame_sched.sv
// Scoreboard bench for pwm_frame_sched: stimulus queues the expected output
// word for each clock, a monitor pops and compares one word per clock.
module tb_pwm_frame_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       wr_valid = 1'b0;
  logic       commit = 1'b0;
  logic [1:0] wr_slot = 2'd0;
  logic [2:0] wr_duty = 3'd0;
  logic       wr_ready, pwm_out, frame_done, busy, commit_pending;
  logic [1:0] slot_idx;
  logic [6:0] obs;

  typedef struct {
    logic [6:0] exp;
    int         tag;
  } exp_t;

  exp_t q_exp[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_tag = 0;

  pwm_frame_sched #(
    .SLOTS(4), .SLOT_TICKS(4), .DW(3), .PRESCALE(1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_slot        (wr_slot),
    .wr_duty        (wr_duty),
    .commit         (commit),
    .pwm_out        (pwm_out),
    .slot_idx       (slot_idx),
    .frame_done     (frame_done),
    .busy           (busy),
    .commit_pending (commit_pending)
  );

  always #5 clk = ~clk;

  assign obs = {slot_idx, wr_ready, commit_pending, busy, frame_done, pwm_out};

  // Expected word layout: {slot, wr_ready, pending, busy, frame_done, pwm}.
  function automatic logic [6:0] pk(input logic pwm, input logic fd, input logic bsy,
                                    input logic pend, input logic [1:0] slot);
    return {slot, ~pend, pend, bsy, fd, pwm};
  endfunction

  task automatic cmp(input string name, input int tag, input logic [6:0] act,
                     input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got {slot,rdy,pend,busy,fd,pwm}=%b, expected %b",
               name, tag, act, exp);
    end
  endtask

  task automatic step(input logic [6:0] exp);
    exp_t e;
    e.exp = exp;
    e.tag = n_tag;
    n_tag++;
    q_exp.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    start    = 1'b0;
    stop     = 1'b0;
    wr_valid = 1'b0;
    commit   = 1'b0;
    wr_slot  = 2'd0;
    wr_duty  = 3'd0;
  endtask

  // One frame at PRESCALE=1: cycle j shows the tick j-1 level from pat[15:0].
  task automatic frame(input logic [15:0] pat, input int last_j, input int wr_j,
                       input int rej_j, input int stop_j);
    for (int j = 1; j <= last_j; j++) begin
      wr_valid = (j == wr_j) || (j == rej_j);
      wr_slot  = (j == rej_j) ? 2'd1 : 2'd0;
      wr_duty  = 3'd0;
      commit   = (j == wr_j);
      stop     = (j == stop_j);
      step(pk(pat[16-j], j == 16, !(stop_j > 0 && j == 16),
              (wr_j > 0) && (j >= wr_j) && (j < 16), 2'((j % 16) / 4)));
      clr();
    end
  endtask

  initial begin : monitor
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        cmp("sb", e.tag, obs, e.exp);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time %0t reached limit 100000", $time);
    $fatal(1);
  end

  initial begin : stim
    #1 rst_n = 1'b0;
    @(negedge clk);
    repeat (3) step(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    rst_n = 1'b1;
    repeat (3) step(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

    // Duties 1,2,3,7 (7 saturates to 4); commit shares the last write cycle.
    wr_valid = 1'b1; wr_slot = 2'd0; wr_duty = 3'd1;
    step(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    wr_slot = 2'd1; wr_duty = 3'd2;
    step(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    wr_slot = 2'd2; wr_duty = 3'd3;
    step(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    wr_slot = 2'd3; wr_duty = 3'd7; commit = 1'b1;
    step(pk(1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
    clr();
    step(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

    start = 1'b1;
    step(pk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    clr();
    frame(16'b1000_1100_1110_1111, 16, -1, -1, -1);
    // Mid-frame commit of slot0=0; a write while pending must be refused.
    frame(16'b1000_1100_1110_1111, 16, 5, 8, -1);
    // New duties take effect; stop in slot 1 drains to the frame end.
    frame(16'b0000_1100_1110_1111, 16, -1, -1, 6);
    repeat (2) step(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

    start = 1'b1; stop = 1'b1;
    step(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    clr();
    step(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

    // Run into slot 2, then reset asynchronously between clock edges.
    start = 1'b1;
    step(pk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    clr();
    frame(16'b0000_1100_1110_1111, 10, -1, -1, -1);
    #2 rst_n = 1'b0;
    #1 cmp("async_rst", 0, obs, pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    repeat (3) step(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    rst_n = 1'b1;
    repeat (3) step(pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

    start = 1'b1;
    step(pk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
    clr();
    frame(16'b0000_0000_0000_0000, 16, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_frame_sched.md
PWM_FRAME_SCHED -- requirements
Module: pwm_frame_sched

Interface
REQ-001 SHALL have parameter SLOTS, default 4, meaning number of duty slots per frame.
REQ-002 SHALL have parameter SLOT_TICKS, default 4, meaning ticks per slot (PWM resolution).
REQ-003 SHALL have parameter DW, default 3, meaning duty width, able to hold the value SLOT_TICKS.
REQ-004 SHALL have parameter PRESCALE, default 2, meaning clk cycles per tick (>=1).
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: begin frame playback.
REQ-008 SHALL have port stop, input, 1 bit: end playback at the next frame boundary.
REQ-009 SHALL have ports wr_valid (input, 1 bit), wr_ready (output, 1 bit), wr_slot (input, clog2(SLOTS) bits) and wr_duty (input, DW bits): shadow duty write handshake.
REQ-010 SHALL have port commit, input, 1 bit: request copy of shadow to active.
REQ-011 SHALL have port pwm_out, output, 1 bit: registered PWM output.
REQ-012 SHALL have port slot_idx, output, clog2(SLOTS) bits: currently playing slot.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame end.
REQ-014 SHALL have ports busy (output, 1 bit; high in RUN or DRAIN) and commit_pending (output, 1 bit; a commit is waiting).

Function
REQ-015 SHALL implement states IDLE, RUN and DRAIN.
REQ-016 SHALL make the following transitions:
- IDLE->RUN on start=1 with stop=0; stop wins if both are asserted.
- RUN->DRAIN on stop=1; start is ignored in RUN and DRAIN.
- DRAIN->IDLE at the frame boundary.
REQ-017 SHALL produce the tick enable from a prescale counter 0..PRESCALE-1, asserted when the counter equals PRESCALE-1, counting only in RUN/DRAIN, and cleared on entry to RUN.
REQ-018 SHALL, on each tick, advance tick_cnt 0..SLOT_TICKS-1; when it wraps, slot_idx SHALL advance 0..SLOTS-1 and wrap to 0.
REQ-019 SHALL define the frame boundary as the tick on which tick_cnt=SLOT_TICKS-1 and slot_idx=SLOTS-1; frame_done SHALL pulse high for exactly the following cycle.
REQ-020 SHALL drive pwm_out=1 in the cycle after (tick_cnt < active[slot_idx]) in RUN/DRAIN, and 0 otherwise: one-cycle latency, 0 in IDLE.
REQ-021 SHALL accept a write when wr_valid&wr_ready; shadow[wr_slot] SHALL be loaded with min(wr_duty, SLOT_TICKS) (saturating).
REQ-022 SHALL drive wr_ready = !commit_pending, so the shadow is frozen while a commit waits.
REQ-023 SHALL set commit_pending on commit=1; a write accepted in the same cycle SHALL be included in that commit.
REQ-024 SHALL, with commit_pending set, copy active<=shadow at the frame boundary in RUN/DRAIN, or on the next cycle in IDLE, and clear commit_pending in the same cycle.
REQ-025 SHALL, on start, begin with slot_idx=0 and tick_cnt=0, and apply any pending commit before the first tick.
REQ-026 SHALL leave duty 0 with the slot low for its full duration, and duty SLOT_TICKS with the slot high for its full duration.

Reset
REQ-027 SHALL, while rst_n=0 (asynchronous assert), force state=IDLE, all counters=0, shadow=0, active=0, pwm_out=0, frame_done=0, commit_pending=0 and busy=0.
REQ-028 SHALL leave wr_ready=1 after reset.
REQ-029 SHALL, on reset asserted mid-frame, abort the frame immediately with no frame_done pulse.
REQ-030 SHALL deassert rst_n synchronously via a two-flop synchronizer inside the block.

Structure
REQ-031 SHALL put the state enumeration and default SLOTS/SLOT_TICKS/PRESCALE constants in shared package pwm_sched_pkg.
REQ-032 SHALL implement the prescale counter and tick enable as sub-module pwm_tick_prescaler, with ports clk, rst_n, en and tick.

Verification
REQ-033 SHALL cover: write duties {1,2,3,4} to slots 0..3, commit, start, PRESCALE=1 -> pwm_out over one frame = 1000 1100 1110 1111, then frame_done pulses once.
REQ-034 SHALL cover: wr_duty=7 with SLOT_TICKS=4 -> slot saturates to 4, output high the whole slot.
REQ-035 SHALL cover: in RUN, write slot0=0 and commit mid-frame -> wr_ready low until boundary, old duty plays to frame end, new frame slot0 all low, commit_pending clears at boundary.
REQ-036 SHALL cover: stop asserted in slot 1 -> busy stays high until frame end, frame_done pulses, state IDLE, pwm_out 0.
REQ-037 SHALL cover: start and stop together in IDLE -> remains IDLE, busy=0.
REQ-038 SHALL cover: rst_n pulled low in slot 2 -> all outputs 0 within the same cycle, no frame_done; after release, a start replays from slot 0 with duties 0.
